// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: ping-pong write steering and display buffer swap control
module frame_buffer_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 640,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    input  logic              frame_done,
    output logic              we0,
    output logic              we1,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              rd_sel,
    output logic              display_en,
    output logic              swap,
    output logic [7:0]        repeat_cnt,
    output logic              err_len
);
    typedef enum logic [1:0] {INIT, RUN, WAIT} state_t;
    state_t state;
    logic accept, at_end, complete;
    assign host_ready = !reset && state != WAIT;
    assign accept     = host_valid && host_ready;
    assign at_end     = waddr == ADDR_W'(DEPTH - 1);
    assign complete   = accept && (host_last || at_end);
    assign we0        = accept && (state == INIT || rd_sel);
    assign we1        = accept && state != INIT && !rd_sel;
    assign wdata      = host_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            rd_sel     <= 1'b0;
            waddr      <= '0;
            display_en <= 1'b0;
            swap       <= 1'b0;
            repeat_cnt <= 8'd0;
            err_len    <= 1'b0;
        end else begin
            swap <= 1'b0;
            if (complete && host_last != at_end) err_len <= 1'b1;
            case (state)
                INIT: begin
                    if (complete) begin
                        state      <= RUN;
                        display_en <= 1'b1;
                        rd_sel     <= 1'b0;
                        waddr      <= '0;
                    end else if (accept) waddr <= waddr + 1'b1;
                end
                RUN: begin
                    if (complete) begin
                        waddr <= '0;
                        if (frame_done) begin
                            rd_sel <= ~rd_sel;
                            swap   <= 1'b1;
                        end else state <= WAIT;
                    end else begin
                        if (accept) waddr <= waddr + 1'b1;
                        if (frame_done && repeat_cnt != 8'hff) repeat_cnt <= repeat_cnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (frame_done) begin
                        rd_sel <= ~rd_sel;
                        swap   <= 1'b1;
                        state  <= RUN;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule
